fetch_unit: RTL and testbench

- Instruction fetch stage, directly upstream of the decoder/router pair.
- Reads 4-byte instructions (op, arg1, arg2, arg3) from a byte-wide instruction memory with fixed 1-cycle read latency.
- Assembles each instruction and presents it as i0..i3 with a valid/ready handshake.
- Replaces the behavioural pc/fetch loop in the top level; supports a branch redirect and reports program completion.

---
 rtl/fetch_unit.sv | 184 ++++++++++++++++++
 tb/tb_fetch_unit.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction fetch stage sitting directly upstream of the decoder/router.
// Reads 4-byte instructions (op, arg1, arg2, arg3) from a byte-wide
// instruction memory with a fixed 1-cycle read latency. Each instruction is
// assembled and presented on i0..i3 together with its index on pc. The stage
// also accepts a branch redirect and reports program completion on done.
//
// Ports:
//   clock, reset       rising-edge clock, synchronous active-high reset
//   mem_addr, mem_rd   byte address {fetch_pc, byte_cnt} and read strobe
//   mem_data           read data, valid the cycle after mem_rd
//   inst_count         number of loaded instructions, static between resets
//   redirect,
//   redirect_pc        single-cycle branch request and target index
//   i0..i3, pc         presented instruction bytes and its index
//   inst_valid,
//   inst_ready         output handshake
//   done               every instruction fetched and the output slot empty
//   fsm_state          current FSM state, for debug and checkers
//
// Handshake: an instruction transfers on every cycle where inst_valid and
// inst_ready are both high. While inst_valid is high and inst_ready is low,
// i0..i3 and pc hold steady. Accept and reload in the same cycle give
// back-to-back instructions with no bubble. A redirect or reset in a cycle
// voids any handshake in that same cycle.
module fetch_unit #(
  parameter int w    = 8,
  parameter int op_w = 8,
  parameter int pc_w = 8
) (
  input  logic            clock,
  input  logic            reset,
  output logic [pc_w+1:0] mem_addr,
  output logic            mem_rd,
  input  logic [w-1:0]    mem_data,
  input  logic [pc_w:0]   inst_count,
  input  logic            redirect,
  input  logic [pc_w-1:0] redirect_pc,
  output logic [op_w-1:0] i0,
  output logic [w-1:0]    i1,
  output logic [w-1:0]    i2,
  output logic [w-1:0]    i3,
  output logic [pc_w-1:0] pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic            done,
  output logic [1:0]      fsm_state
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HOLD  = 2'd2,
    ST_END   = 2'd3
  } state_t;

  state_t state, state_next;

  // One bit wider than an instruction index so that a full program of
  // 2**pc_w instructions finishes instead of wrapping back to index 0.
  logic [pc_w:0]   fetch_pc;
  logic [1:0]      byte_cnt;
  logic [w-1:0]    asm0, asm1, asm2, asm3;

  logic            slot_free;
  logic            rd_issue;
  logic            load;
  logic            park;
  logic [w-1:0]    last_byte;

  assign slot_free = !inst_valid || inst_ready;
  assign mem_addr  = {fetch_pc[pc_w-1:0], byte_cnt};
  assign mem_rd    = rd_issue && !reset;
  assign fsm_state = state;

  // The last byte comes straight off the memory bus in DRAIN, or from the
  // parked copy when the instruction had to wait in HOLD.
  assign last_byte = (state == ST_DRAIN) ? mem_data : asm3;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_FETCH;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    rd_issue   = 1'b0;
    load       = 1'b0;
    park       = 1'b0;
    case (state)
      ST_FETCH: begin
        // The end-of-program check is made only on an instruction boundary,
        // so a started instruction is always completed.
        if (byte_cnt == 2'd0 && fetch_pc >= inst_count) begin
          state_next = ST_END;
        end else begin
          rd_issue = 1'b1;
          if (byte_cnt == 2'd3) begin
            state_next = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (slot_free) begin
          load       = 1'b1;
          state_next = ST_FETCH;
        end else begin
          park       = 1'b1;
          state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (slot_free) begin
          load       = 1'b1;
          state_next = ST_FETCH;
        end
      end
      ST_END: begin
        state_next = ST_END;
      end
      default: begin
        state_next = ST_FETCH;
      end
    endcase
    if (redirect) begin
      state_next = ST_FETCH;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc   <= '0;
      byte_cnt   <= '0;
      asm0       <= '0;
      asm1       <= '0;
      asm2       <= '0;
      asm3       <= '0;
      i0         <= '0;
      i1         <= '0;
      i2         <= '0;
      i3         <= '0;
      pc         <= '0;
      inst_valid <= 1'b0;
      done       <= 1'b0;
    end else if (redirect) begin
      // Clearing byte_cnt means the read issued this cycle is never captured.
      fetch_pc   <= {1'b0, redirect_pc};
      byte_cnt   <= '0;
      inst_valid <= 1'b0;
      done       <= 1'b0;
    end else begin
      if (rd_issue) begin
        byte_cnt <= byte_cnt + 2'd1;
        // Data for the byte issued last cycle arrives now.
        case (byte_cnt)
          2'd1:    asm0 <= mem_data;
          2'd2:    asm1 <= mem_data;
          2'd3:    asm2 <= mem_data;
          default: ;
        endcase
      end
      if (park) begin
        asm3 <= mem_data;
      end
      if (load) begin
        i0         <= op_w'(asm0);
        i1         <= asm1;
        i2         <= asm2;
        i3         <= last_byte;
        pc         <= fetch_pc[pc_w-1:0];
        inst_valid <= 1'b1;
        fetch_pc   <= fetch_pc + 1'b1;
        byte_cnt   <= '0;
      end else if (inst_valid && inst_ready) begin
        inst_valid <= 1'b0;
      end
      done <= (state == ST_END) && !inst_valid;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
// Directed scenarios for the fetch stage timing followed by randomized runs.
// In the randomized runs, a transaction-level model predicts the ordered list
// of instructions that the consumer accepts.
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_data = 8'h00;
  logic [8:0]  inst_count = 9'd0;
  logic        redirect = 1'b0;
  logic [7:0]  redirect_pc = 8'd0;
  logic [7:0]  i0, i1, i2, i3;
  logic [7:0]  pc;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic        done;
  logic [1:0]  fsm_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  mem [0:1023];
  logic [39:0] exp_q[$];

  // ---------------- clock / reset / memory ----------------
  always #5 clock = ~clock;

  // Byte-wide memory with a fixed 1-cycle read latency.
  always @(posedge clock) begin
    if (mem_rd) mem_data <= mem[mem_addr];
  end

  fetch_unit #(.w(8), .op_w(8), .pc_w(8)) dut (
    .clock(clock), .reset(reset),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
    .inst_count(inst_count), .redirect(redirect), .redirect_pc(redirect_pc),
    .i0(i0), .i1(i1), .i2(i2), .i3(i3), .pc(pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .done(done),
    .fsm_state(fsm_state)
  );

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [39:0] exp_word(input int p);
    return {p[7:0], mem[4*p], mem[4*p+1], mem[4*p+2], mem[4*p+3]};
  endfunction

  function automatic logic [39:0] obs_word();
    return {pc, i0, i1, i2, i3};
  endfunction

  // After a reset or redirect to index 'from', the consumer must see
  // instructions from..inst_count-1 in order.
  task automatic refill(input int from);
    exp_q.delete();
    for (int p = from; p < int'(inst_count); p++) exp_q.push_back(exp_word(p));
  endtask

  task automatic seq_image();
    for (int a = 0; a < 1024; a++) mem[a] = 8'(a + 1);
  endtask

  task automatic rand_image();
    for (int a = 0; a < 1024; a++) mem[a] = 8'($urandom_range(0, 255));
  endtask

  // Returns with reset just released: the current cycle is T0.
  task automatic start(input int cnt);
    reset       = 1'b1;
    redirect    = 1'b0;
    inst_ready  = 1'b0;
    inst_count  = cnt[8:0];
    tick();
    tick();
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Sequential image, always ready.
    seq_image();
    start(2);
    inst_ready = 1'b1;
    for (int t = 0; t < 16; t++) begin
      @(negedge clock);
      if (t == 0) check("reset_outs", {inst_valid, done, obs_word()}, 0);
      if (t < 4) begin
        check("t1_rd", mem_rd, 1);
        check("t1_addr", mem_addr, t);
      end
      if (t == 4) check("t1_drain_rd", mem_rd, 0);
      if (t < 5) check("t1_early_valid", inst_valid, 0);
      if (t == 5) begin
        check("t1_valid0", inst_valid, 1);
        check("t1_inst0", obs_word(), 40'h00_01_02_03_04);
      end
      if (t > 5 && t < 10) check("t1_gap", inst_valid, 0);
      if (t >= 5 && t < 9) check("t1_addr1", mem_addr, t - 1);
      if (t == 10) begin
        check("t1_valid1", inst_valid, 1);
        check("t1_inst1", obs_word(), 40'h01_05_06_07_08);
      end
      if (t == 11) check("t1_done_early", done, 0);
      if (t >= 12) check("t1_done", done, 1);
      if (t >= 9) check("t1_rd_idle", mem_rd, 0);
      tick();
    end

    // Consumer stalls until T20.
    start(2);
    for (int t = 0; t < 25; t++) begin
      inst_ready = (t >= 20);
      @(negedge clock);
      if (t >= 5 && t <= 20) begin
        check("t2_hold_valid", inst_valid, 1);
        check("t2_hold_inst", obs_word(), 40'h00_01_02_03_04);
      end
      if (t >= 10 && t <= 20) check("t2_hold_rd", mem_rd, 0);
      if (t == 21) begin
        check("t2_valid1", inst_valid, 1);
        check("t2_inst1", obs_word(), 40'h01_05_06_07_08);
      end
      if (t == 22) check("t2_drained", inst_valid, 0);
      if (t == 23) check("t2_done", done, 1);
      tick();
    end

    // Redirect to index 3 in the middle of fetching index 0.
    rand_image();
    start(4);
    inst_ready  = 1'b1;
    redirect_pc = 8'd3;
    for (int t = 0; t < 15; t++) begin
      redirect = (t == 2);
      @(negedge clock);
      if (t >= 3 && t <= 6) begin
        check("t3_rd", mem_rd, 1);
        check("t3_addr", mem_addr, 12 + t - 3);
      end
      if (t < 8) check("t3_no_idx0", inst_valid, 0);
      if (t == 8) begin
        check("t3_valid", inst_valid, 1);
        check("t3_inst", obs_word(), exp_word(3));
      end
      if (t >= 10) check("t3_done", done, 1);
      tick();
    end
    redirect = 1'b0;

    // Empty program.
    start(0);
    for (int t = 0; t < 7; t++) begin
      @(negedge clock);
      check("t4_rd", mem_rd, 0);
      check("t4_valid", inst_valid, 0);
      check("t4_done", done, (t >= 2) ? 1'b1 : 1'b0);
      tick();
    end

    // Full 256-instruction program, redirect to the last index.
    seq_image();
    start(256);
    inst_ready  = 1'b1;
    redirect_pc = 8'd255;
    for (int t = 0; t < 13; t++) begin
      redirect = (t == 0);
      @(negedge clock);
      if (t >= 1 && t <= 4) begin
        check("t5_rd", mem_rd, 1);
        check("t5_addr", mem_addr, 1020 + t - 1);
      end
      if (t >= 5) check("t5_no_wrap", mem_rd, 0);
      if (t == 6) begin
        check("t5_valid", inst_valid, 1);
        check("t5_inst", obs_word(), exp_word(255));
      end
      if (t >= 8) check("t5_done", done, 1);
      tick();
    end
    redirect = 1'b0;

    // Reset while an instruction is parked in HOLD.
    start(2);
    for (int t = 0; t < 14; t++) begin
      reset = (t >= 12);
      @(negedge clock);
      if (t == 12) check("t6_pre_valid", inst_valid, 1);
      if (t == 13) begin
        check("t6_reset_outs", {inst_valid, done, obs_word()}, 0);
        check("t6_reset_rd", mem_rd, 0);
      end
      tick();
    end
    reset      = 1'b0;
    inst_ready = 1'b1;
    for (int t = 0; t < 7; t++) begin
      @(negedge clock);
      if (t == 0) begin
        check("t6_rd0", mem_rd, 1);
        check("t6_addr0", mem_addr, 0);
      end
      if (t == 5) begin
        check("t6_valid", inst_valid, 1);
        check("t6_inst", obs_word(), 40'h00_01_02_03_04);
      end
      tick();
    end

    // Randomized runs against the transaction-level model.
    for (int run = 0; run < 30; run++) begin
      int cnt;
      int redirects_left;
      int reset_at;
      logic prev_hold;
      logic [39:0] prev_word;
      logic finished;
      rand_image();
      cnt = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 10));
      start(cnt);
      refill(0);
      redirects_left = 2;
      reset_at  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(3, 40)) : -1;
      prev_hold = 1'b0;
      prev_word = '0;
      finished  = 1'b0;
      for (int c = 0; c < 3000 && !finished; c++) begin
        inst_ready = ($urandom_range(0, 99) < 60);
        redirect   = 1'b0;
        if (redirects_left > 0 && $urandom_range(0, 39) == 0) begin
          int r;
          r = int'($urandom_range(0, cnt + 1));
          if (r > 255) r = 255;
          redirect_pc = r[7:0];
          redirect    = 1'b1;
          redirects_left--;
        end
        reset = (c == reset_at);
        @(negedge clock);
        if (mem_rd) check("rd_bound", {1'b0, mem_addr[9:2]} < inst_count, 1);
        if (prev_hold) begin
          check("hold_valid", inst_valid, 1);
          check("hold_stable", obs_word(), prev_word);
        end
        if (done) begin
          check("done_valid", inst_valid, 0);
          check("done_empty", exp_q.size(), 0);
        end
        if (reset) begin
          refill(0);
        end else if (redirect) begin
          refill(int'(redirect_pc));
        end else if (inst_valid && inst_ready) begin
          check("accept_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) check("accept_inst", obs_word(), exp_q.pop_front());
        end
        prev_hold = inst_valid && !inst_ready && !redirect && !reset;
        prev_word = obs_word();
        if (done && exp_q.size() == 0 && !reset && !redirect) finished = 1'b1;
        tick();
      end
      reset    = 1'b0;
      redirect = 1'b0;
      check("run_complete", finished, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
